id_stage: RTL and testbench
===========================

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameter XLEN, default 64, datapath width (CPU_WIDTH).
REQ-002 Parameter RW, default 5, register-index width (REG_WIDTH).
REQ-003 clk_i  in  1  single clock; all state updates on posedge.
REQ-004 rst_i  in  1  reset, synchronous, active-high.
REQ-005 D_opcode_i  in  7  opcode of instruction in decode.
REQ-006 D_rs1_i / D_rs2_i / D_rd_i  in  RW each  rs1, rs2, rd fields.
REQ-007 E_dstE_i, e_valE_i  in  RW, XLEN  execute-stage ALU destination and result.
REQ-008 M_dstM_i, m_valM_i  in  RW, XLEN  memory-stage load destination and loaded data.
REQ-009 M_dstE_i, M_valE_i  in  RW, XLEN  memory-stage ALU destination and value.
REQ-010 W_dstM_i, W_valM_i, W_dstE_i, W_valE_i  in  RW, XLEN  writeback destinations and values.
REQ-011 d_srcA_o, d_srcB_o, d_dstE_o, d_dstM_o  out  RW each  decoded register IDs.
REQ-012 d_valA_o, d_valB_o  out  XLEN each  forwarded operand values.
REQ-013 dbg_raddr_i  in  RW, dbg_rdata_o  out  XLEN  debug register-file read port.

Function
REQ-014 Opcodes: IR 0110011, II 0010011, IIL 0000011, IS 0100011, IB 1100011, IJ 1101111, IJALR 1100111, ILUI 0110111, IAUIPC 0010111; RNONE = RZERO = 0.
REQ-015 d_srcA_o SHALL be D_rs1_i for IR, II, IIL, IS, IJALR, IB; else RNONE.
REQ-016 d_srcB_o SHALL be D_rs2_i for IR, IS, IB; else RNONE.
REQ-017 d_dstE_o SHALL be D_rd_i for IR, II, IJ, IJALR, ILUI, IAUIPC; else RNONE.
REQ-018 d_dstM_o SHALL be D_rd_i for IIL; else RNONE.
REQ-019 Register file: 32 x XLEN; x0 reads 0 always and is never written.
REQ-020 Posedge write: W_dstE_i != 0 writes W_valE_i; W_dstM_i != 0 writes W_valM_i; same nonzero index on both -> W_valM_i wins.
REQ-021 All decode, read and forwarding paths SHALL be combinational (zero latency).
REQ-022 Forwarding per operand (src = d_srcA_o or d_srcB_o), first match wins: src==0 -> 0; E_dstE_i -> e_valE_i; M_dstM_i -> m_valM_i; M_dstE_i -> M_valE_i; W_dstM_i -> W_valM_i; W_dstE_i -> W_valE_i; else register-file value.
REQ-023 A destination ID of 0 SHALL never match (x0 not forwarded).
REQ-024 Writeback value visible through W forwarding in same cycle, and through register file from next cycle.
REQ-025 dbg_rdata_o SHALL combinationally return register dbg_raddr_i (0 for index 0).

Reset
REQ-026 On posedge clk_i with rst_i=1 all 32 registers SHALL clear to 0; writeback writes that cycle are discarded.
REQ-027 Outputs are combinational; during reset they reflect cleared registers plus forwarding inputs.

Structure
REQ-028 Shared package id_pkg: XLEN/RW defaults, opcode constants, RNONE, RZERO.
REQ-029 One sub-module operand_bypass (priority mux, instantiated twice or dual-ported), register file and decode in id_stage.

Verification
REQ-030 Reset, then opcode IR rs1=1 rs2=2 rd=3, no dst matches -> d_valA_o=0, d_valB_o=0, d_dstE_o=3, d_dstM_o=0.
REQ-031 W_dstE_i=5, W_valE_i=0x55 for one cycle, then IR rs1=5 -> d_valA_o=0x55 from register file; dbg_raddr_i=5 -> 0x55.
REQ-032 Register x7=0x10; E_dstE_i=7 e_valE_i=0xAA, M_dstE_i=7 M_valE_i=0xBB, IR rs1=7 -> d_valA_o=0xAA; drop E match -> 0xBB.
REQ-033 M_dstM_i=4 m_valM_i=0x11 and M_dstE_i=4 M_valE_i=0x22, IS rs2=4 -> d_valB_o=0x11.
REQ-034 E_dstE_i=0 e_valE_i=0xFF, IR rs1=0 -> d_valA_o=0; W_dstE_i=0 write -> x0 stays 0.
REQ-035 IIL rd=9 -> d_dstM_o=9, d_dstE_o=0, d_srcB_o=0; ILUI rs1=3 -> d_srcA_o=0, d_dstE_o=rd.

Source files
------------

// File: rtl/id_pkg.sv
// Shared decode-stage definitions: datapath defaults, opcode encodings, register IDs.
package id_pkg;

    localparam int XLEN_DEF = 64;
    localparam int RW_DEF   = 5;
    localparam int NREGS    = 32;

    localparam logic [6:0] OP_IR     = 7'b0110011;
    localparam logic [6:0] OP_II     = 7'b0010011;
    localparam logic [6:0] OP_IIL    = 7'b0000011;
    localparam logic [6:0] OP_IS     = 7'b0100011;
    localparam logic [6:0] OP_IB     = 7'b1100011;
    localparam logic [6:0] OP_IJ     = 7'b1101111;
    localparam logic [6:0] OP_IJALR  = 7'b1100111;
    localparam logic [6:0] OP_ILUI   = 7'b0110111;
    localparam logic [6:0] OP_IAUIPC = 7'b0010111;

    // "No register" and x0 share the same encoding.
    localparam int RNONE = 0;
    localparam int RZERO = 0;

endpackage

// File: rtl/operand_bypass.sv
// Purpose: selects one source operand from in-flight pipeline results or the register file.
// Latency: combinational, zero cycles.
// Backpressure: none; pure datapath mux with no handshake.
module operand_bypass
    import id_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int RW   = RW_DEF
) (
    input  logic [RW-1:0]   src,
    input  logic [XLEN-1:0] rf_val,
    input  logic [RW-1:0]   e_dst_e,
    input  logic [XLEN-1:0] e_val_e,
    input  logic [RW-1:0]   m_dst_m,
    input  logic [XLEN-1:0] m_val_m,
    input  logic [RW-1:0]   m_dst_e,
    input  logic [XLEN-1:0] m_val_e,
    input  logic [RW-1:0]   w_dst_m,
    input  logic [XLEN-1:0] w_val_m,
    input  logic [RW-1:0]   w_dst_e,
    input  logic [XLEN-1:0] w_val_e,
    output logic [XLEN-1:0] val
);

    localparam logic [RW-1:0] REG_ZERO = RW'(RZERO);

    logic hit_e_e;
    logic hit_m_m;
    logic hit_m_e;
    logic hit_w_m;
    logic hit_w_e;

    // A zero destination means "writes nothing", so it must never claim a match.
    assign hit_e_e = (e_dst_e != REG_ZERO) && (e_dst_e == src);
    assign hit_m_m = (m_dst_m != REG_ZERO) && (m_dst_m == src);
    assign hit_m_e = (m_dst_e != REG_ZERO) && (m_dst_e == src);
    assign hit_w_m = (w_dst_m != REG_ZERO) && (w_dst_m == src);
    assign hit_w_e = (w_dst_e != REG_ZERO) && (w_dst_e == src);

    // Youngest producer first; within a stage the load result outranks the ALU result.
    always_comb begin
        val = rf_val;
        if (src == REG_ZERO) begin
            val = '0;
        end else if (hit_e_e) begin
            val = e_val_e;
        end else if (hit_m_m) begin
            val = m_val_m;
        end else if (hit_m_e) begin
            val = m_val_e;
        end else if (hit_w_m) begin
            val = w_val_m;
        end else if (hit_w_e) begin
            val = w_val_e;
        end
    end

endmodule

// File: rtl/id_stage.sv
// Purpose: instruction decode; register IDs, 32-entry register file, operand forwarding.
// Latency: all outputs combinational; register writes land on the next posedge.
// Backpressure: none; stalls are handled by the surrounding pipeline registers.
module id_stage
    import id_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int RW   = RW_DEF
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [6:0]      D_opcode_i,
    input  logic [RW-1:0]   D_rs1_i,
    input  logic [RW-1:0]   D_rs2_i,
    input  logic [RW-1:0]   D_rd_i,
    input  logic [RW-1:0]   E_dstE_i,
    input  logic [XLEN-1:0] e_valE_i,
    input  logic [RW-1:0]   M_dstM_i,
    input  logic [XLEN-1:0] m_valM_i,
    input  logic [RW-1:0]   M_dstE_i,
    input  logic [XLEN-1:0] M_valE_i,
    input  logic [RW-1:0]   W_dstM_i,
    input  logic [XLEN-1:0] W_valM_i,
    input  logic [RW-1:0]   W_dstE_i,
    input  logic [XLEN-1:0] W_valE_i,
    output logic [RW-1:0]   d_srcA_o,
    output logic [RW-1:0]   d_srcB_o,
    output logic [RW-1:0]   d_dstE_o,
    output logic [RW-1:0]   d_dstM_o,
    output logic [XLEN-1:0] d_valA_o,
    output logic [XLEN-1:0] d_valB_o,
    input  logic [RW-1:0]   dbg_raddr_i,
    output logic [XLEN-1:0] dbg_rdata_o
);

    localparam logic [RW-1:0] REG_NONE = RW'(RNONE);
    localparam logic [RW-1:0] REG_ZERO = RW'(RZERO);

    logic [XLEN-1:0] rf [NREGS];
    logic [XLEN-1:0] rf_a;
    logic [XLEN-1:0] rf_b;

    always_comb begin
        d_srcA_o = REG_NONE;
        d_srcB_o = REG_NONE;
        d_dstE_o = REG_NONE;
        d_dstM_o = REG_NONE;
        case (D_opcode_i)
            OP_IR: begin
                d_srcA_o = D_rs1_i;
                d_srcB_o = D_rs2_i;
                d_dstE_o = D_rd_i;
            end
            OP_II: begin
                d_srcA_o = D_rs1_i;
                d_dstE_o = D_rd_i;
            end
            OP_IIL: begin
                d_srcA_o = D_rs1_i;
                d_dstM_o = D_rd_i;
            end
            OP_IS, OP_IB: begin
                d_srcA_o = D_rs1_i;
                d_srcB_o = D_rs2_i;
            end
            OP_IJALR: begin
                d_srcA_o = D_rs1_i;
                d_dstE_o = D_rd_i;
            end
            OP_IJ, OP_ILUI, OP_IAUIPC: begin
                d_dstE_o = D_rd_i;
            end
            default: ;
        endcase
    end

    // Load data is written after the ALU result so it wins when both target one register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREGS; i++) begin
                rf[i] <= '0;
            end
        end else begin
            if (W_dstE_i != REG_ZERO) begin
                rf[W_dstE_i] <= W_valE_i;
            end
            if (W_dstM_i != REG_ZERO) begin
                rf[W_dstM_i] <= W_valM_i;
            end
        end
    end

    assign rf_a        = (d_srcA_o    == REG_ZERO) ? '0 : rf[d_srcA_o];
    assign rf_b        = (d_srcB_o    == REG_ZERO) ? '0 : rf[d_srcB_o];
    assign dbg_rdata_o = (dbg_raddr_i == REG_ZERO) ? '0 : rf[dbg_raddr_i];

    operand_bypass #(.XLEN(XLEN), .RW(RW)) u_bypass_a (
        .src     (d_srcA_o),
        .rf_val  (rf_a),
        .e_dst_e (E_dstE_i),
        .e_val_e (e_valE_i),
        .m_dst_m (M_dstM_i),
        .m_val_m (m_valM_i),
        .m_dst_e (M_dstE_i),
        .m_val_e (M_valE_i),
        .w_dst_m (W_dstM_i),
        .w_val_m (W_valM_i),
        .w_dst_e (W_dstE_i),
        .w_val_e (W_valE_i),
        .val     (d_valA_o)
    );

    operand_bypass #(.XLEN(XLEN), .RW(RW)) u_bypass_b (
        .src     (d_srcB_o),
        .rf_val  (rf_b),
        .e_dst_e (E_dstE_i),
        .e_val_e (e_valE_i),
        .m_dst_m (M_dstM_i),
        .m_val_m (m_valM_i),
        .m_dst_e (M_dstE_i),
        .m_val_e (M_valE_i),
        .w_dst_m (W_dstM_i),
        .w_val_m (W_valM_i),
        .w_dst_e (W_dstE_i),
        .w_val_e (W_valE_i),
        .val     (d_valB_o)
    );

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: decode, register file, reset and forwarding priority.
module tb_id_stage;

    localparam logic [6:0] OP_IR   = 7'b0110011;
    localparam logic [6:0] OP_IIL  = 7'b0000011;
    localparam logic [6:0] OP_IS   = 7'b0100011;
    localparam logic [6:0] OP_IJ   = 7'b1101111;
    localparam logic [6:0] OP_ILUI = 7'b0110111;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [6:0]  D_opcode_i;
    logic [4:0]  D_rs1_i, D_rs2_i, D_rd_i;
    logic [4:0]  E_dstE_i, M_dstM_i, M_dstE_i, W_dstM_i, W_dstE_i;
    logic [63:0] e_valE_i, m_valM_i, M_valE_i, W_valM_i, W_valE_i;
    logic [4:0]  d_srcA_o, d_srcB_o, d_dstE_o, d_dstM_o;
    logic [63:0] d_valA_o, d_valB_o;
    logic [4:0]  dbg_raddr_i;
    logic [63:0] dbg_rdata_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    id_stage dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .D_opcode_i  (D_opcode_i),
        .D_rs1_i     (D_rs1_i),
        .D_rs2_i     (D_rs2_i),
        .D_rd_i      (D_rd_i),
        .E_dstE_i    (E_dstE_i),
        .e_valE_i    (e_valE_i),
        .M_dstM_i    (M_dstM_i),
        .m_valM_i    (m_valM_i),
        .M_dstE_i    (M_dstE_i),
        .M_valE_i    (M_valE_i),
        .W_dstM_i    (W_dstM_i),
        .W_valM_i    (W_valM_i),
        .W_dstE_i    (W_dstE_i),
        .W_valE_i    (W_valE_i),
        .d_srcA_o    (d_srcA_o),
        .d_srcB_o    (d_srcB_o),
        .d_dstE_o    (d_dstE_o),
        .d_dstM_o    (d_dstM_o),
        .d_valA_o    (d_valA_o),
        .d_valB_o    (d_valB_o),
        .dbg_raddr_i (dbg_raddr_i),
        .dbg_rdata_o (dbg_rdata_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_fwd();
        E_dstE_i = 0; e_valE_i = 0;
        M_dstM_i = 0; m_valM_i = 0;
        M_dstE_i = 0; M_valE_i = 0;
        W_dstM_i = 0; W_valM_i = 0;
        W_dstE_i = 0; W_valE_i = 0;
    endtask

    task automatic set_insn(input logic [6:0] op, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [4:0] rd);
        D_opcode_i = op; D_rs1_i = rs1; D_rs2_i = rs2; D_rd_i = rd;
    endtask

    // One clock edge; inputs change 1ns after it so nothing races the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i = 1'b1;
        clear_fwd();
        set_insn(7'h00, 0, 0, 0);
        dbg_raddr_i = 0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        dbg_raddr_i = 5'd5; #1;
        check("reset_x5", dbg_rdata_o, 64'h0);
        dbg_raddr_i = 5'd31; #1;
        check("reset_x31", dbg_rdata_o, 64'h0);

        set_insn(OP_IR, 5'd1, 5'd2, 5'd3); #1;
        check("ir_srcA", d_srcA_o, 64'd1);
        check("ir_srcB", d_srcB_o, 64'd2);
        check("ir_valA", d_valA_o, 64'h0);
        check("ir_valB", d_valB_o, 64'h0);
        check("ir_dstE", d_dstE_o, 64'd3);
        check("ir_dstM", d_dstM_o, 64'd0);

        W_dstE_i = 5'd5; W_valE_i = 64'h55;
        set_insn(OP_IR, 5'd5, 5'd0, 5'd1); #1;
        check("w_fwd_same_cycle", d_valA_o, 64'h55);
        tick();
        clear_fwd(); #1;
        check("rf_read_x5", d_valA_o, 64'h55);
        dbg_raddr_i = 5'd5; #1;
        check("dbg_x5", dbg_rdata_o, 64'h55);

        W_dstE_i = 5'd7; W_valE_i = 64'h10;
        tick();
        clear_fwd();
        E_dstE_i = 5'd7; e_valE_i = 64'hAA;
        M_dstE_i = 5'd7; M_valE_i = 64'hBB;
        set_insn(OP_IR, 5'd7, 5'd0, 5'd2); #1;
        check("fwd_e_first", d_valA_o, 64'hAA);
        E_dstE_i = 0; #1;
        check("fwd_m_alu", d_valA_o, 64'hBB);
        M_dstE_i = 0; #1;
        check("rf_x7", d_valA_o, 64'h10);

        M_dstM_i = 5'd4; m_valM_i = 64'h11;
        M_dstE_i = 5'd4; M_valE_i = 64'h22;
        set_insn(OP_IS, 5'd7, 5'd4, 5'd9); #1;
        check("is_mload_wins", d_valB_o, 64'h11);
        check("is_dstE", d_dstE_o, 64'd0);
        check("is_valA_rf", d_valA_o, 64'h10);
        clear_fwd();

        W_dstM_i = 5'd6; W_valM_i = 64'h66;
        W_dstE_i = 5'd6; W_valE_i = 64'h77;
        set_insn(OP_IR, 5'd6, 5'd6, 5'd1); #1;
        check("w_load_fwd_wins", d_valA_o, 64'h66);
        tick();
        clear_fwd();
        dbg_raddr_i = 5'd6; #1;
        check("rf_load_write_wins", dbg_rdata_o, 64'h66);
        check("rf_valB_x6", d_valB_o, 64'h66);

        E_dstE_i = 5'd0; e_valE_i = 64'hFF;
        set_insn(OP_IR, 5'd0, 5'd0, 5'd1); #1;
        check("x0_no_fwd", d_valA_o, 64'h0);
        clear_fwd();
        W_dstE_i = 5'd0; W_valE_i = 64'hDEAD;
        tick();
        clear_fwd();
        dbg_raddr_i = 5'd0; #1;
        check("x0_not_written", dbg_rdata_o, 64'h0);

        set_insn(OP_IIL, 5'd2, 5'd3, 5'd9); #1;
        check("iil_dstM", d_dstM_o, 64'd9);
        check("iil_dstE", d_dstE_o, 64'd0);
        check("iil_srcB", d_srcB_o, 64'd0);
        check("iil_srcA", d_srcA_o, 64'd2);
        set_insn(OP_ILUI, 5'd3, 5'd4, 5'd8); #1;
        check("lui_srcA", d_srcA_o, 64'd0);
        check("lui_dstE", d_dstE_o, 64'd8);
        set_insn(OP_IJ, 5'd5, 5'd5, 5'd10); #1;
        check("jal_srcA", d_srcA_o, 64'd0);
        check("jal_valA", d_valA_o, 64'h0);
        check("jal_dstE", d_dstE_o, 64'd10);
        set_insn(7'h7F, 5'd5, 5'd6, 5'd11); #1;
        check("bad_op_srcA", d_srcA_o, 64'd0);
        check("bad_op_dstE", d_dstE_o, 64'd0);

        rst_i = 1'b1;
        W_dstE_i = 5'd5; W_valE_i = 64'h99;
        tick();
        rst_i = 1'b0;
        clear_fwd();
        dbg_raddr_i = 5'd5; #1;
        check("reset_drops_write", dbg_rdata_o, 64'h0);
        dbg_raddr_i = 5'd7; #1;
        check("reset_clears_x7", dbg_rdata_o, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
